// File: rtl/axis_sample_pkg.sv
// Shared definitions for ADC-driven AXI-Stream sample sources.
// Holds default widths and the offset-binary to signed conversion.
package axis_sample_pkg;

    localparam int DEF_ADC_W  = 12;
    localparam int DEF_AXIS_W = 16;
    localparam int DROP_CNT_W = 16;

    localparam logic [DEF_ADC_W-1:0] ADC_MID = {1'b1, {(DEF_ADC_W-1){1'b0}}};

    // Subtracting mid-scale flips the MSB; the result is left-aligned so
    // full-scale ADC swing maps onto full-scale signed output.
    function automatic logic [DEF_AXIS_W-1:0] adc_to_s16(input logic [DEF_ADC_W-1:0] raw);
        logic [DEF_ADC_W-1:0] centred;
        centred = raw - ADC_MID;
        return {centred, {(DEF_AXIS_W-DEF_ADC_W){1'b0}}};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head word.
// Pointers carry one extra wrap bit to distinguish full from empty.
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [W-1:0]  head_reg, head_next;
    logic [PW-1:0] level_reg;
    logic          wr_ok, rd_ok, empty_next;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A write at full is only legal when the head slot is freed this cycle.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    assign wr_ptr_next = wr_ptr_reg + PW'(wr_ok);
    assign rd_ptr_next = rd_ptr_reg + PW'(rd_ok);
    assign empty_next  = (wr_ptr_next == rd_ptr_next);

    always_comb begin
        head_next = head_reg;
        if (!empty_next) begin
            // The next head is the word being written now when the FIFO
            // would otherwise run dry; bypass the array in that case.
            if (wr_ok && (rd_ptr_next == wr_ptr_reg))
                head_next = wr_data;
            else
                head_next = mem[rd_ptr_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
            level_reg  <= wr_ptr_next - rd_ptr_next;
        end
    end

    assign rd_data = head_reg;
    assign level   = level_reg;

endmodule

// File: rtl/axis_adc_sample_src.sv
// Strobed offset-binary ADC samples to a signed AXI-Stream master,
// buffered in a FWFT FIFO with sticky overflow and a saturating drop count.
module axis_adc_sample_src
    import axis_sample_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADC_W  = axis_sample_pkg::DEF_ADC_W,
    parameter int AXIS_W = axis_sample_pkg::DEF_AXIS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adc_valid,
    input  logic [ADC_W-1:0]          adc_data,
    output logic                      m_axis_tvalid,
    output logic [AXIS_W-1:0]         m_axis_tdata,
    input  logic                      m_axis_tready,
    input  logic                      overflow_clr,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    logic [AXIS_W-1:0]     conv_data;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, drop;
    logic                  overflow_reg;
    logic [DROP_CNT_W-1:0] drop_count_reg;

    generate
        if (ADC_W == DEF_ADC_W && AXIS_W == DEF_AXIS_W) begin : g_pkg_conv
            assign conv_data = adc_to_s16(adc_data);
        end else begin : g_generic_conv
            assign conv_data = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0],
                                {(AXIS_W-ADC_W){1'b0}}};
        end
    endgenerate

    assign m_axis_tvalid = !fifo_empty;
    assign pop  = m_axis_tvalid && m_axis_tready;
    assign push = adc_valid && (!fifo_full || pop);
    assign drop = adc_valid && fifo_full && !pop;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .W     (AXIS_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (conv_data),
        .rd_en   (pop),
        .rd_data (m_axis_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (overflow_clr)
                drop_count_reg <= DROP_CNT_W'(1);
            else if (drop_count_reg != '1)
                drop_count_reg <= drop_count_reg + 1'b1;
        end else if (overflow_clr) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end
    end

    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_axis_adc_sample_src.sv
// Scoreboard bench for axis_adc_sample_src: expected samples are queued on
// strobe and compared as each AXI-Stream transfer happens.
module tb_axis_adc_sample_src;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic        m_axis_tvalid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        overflow;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic        hold_seen = 1'b0;
    logic [15:0] hold_data = '0;

    always #5 clk = ~clk;

    axis_adc_sample_src #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .overflow_clr  (overflow_clr),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .fifo_level    (fifo_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_conv(input logic [11:0] x);
        int v;
        v = (int'(x) - 2048) * 16;
        return v[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] x, input bit accept);
        adc_valid = 1'b1;
        adc_data  = x;
        if (accept)
            exp_q.push_back(ref_conv(x));
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (m_axis_tvalid && n < 100) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 32'(m_axis_tvalid), 32'd0);
    endtask

    // Handshake monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            hold_seen = 1'b0;
        end else begin
            if (hold_seen) begin
                check_eq("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
                check_eq("hold_tdata", 32'(m_axis_tdata), 32'(hold_data));
            end
            hold_seen = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra_xfer", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    $display("xfer tdata=0x%04h expected=0x%04h", m_axis_tdata, e);
                    check_eq("sb_tdata", 32'(m_axis_tdata), 32'(e));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] conv_in  [4];
        logic [15:0] conv_exp [4];
        conv_in  = '{12'h000, 12'h800, 12'hFFF, 12'h801};
        conv_exp = '{16'h8000, 16'h0000, 16'h7FF0, 16'h0010};

        repeat (3) tick();
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("init_overflow", 32'(overflow), 32'd0);
        check_eq("init_drops", 32'(drop_count), 32'd0);

        // Conversion with a free-running sink: visible one cycle after strobe.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(conv_in[i], 1'b1);
            check_eq("conv_tvalid", 32'(m_axis_tvalid), 32'd1);
            check_eq("conv_tdata", 32'(m_axis_tdata), 32'(conv_exp[i]));
            tick();
        end
        check_eq("conv_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: five samples held, then streamed back-to-back.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(12'($urandom_range(0, 4095)), 1'b1);
        check_eq("bp_level", 32'(fifo_level), 32'd5);
        check_eq("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
        check_eq("bp_head", 32'(m_axis_tdata), 32'(exp_q[0]));
        m_axis_tready = 1'b1;
        begin
            int n = 0;
            while (m_axis_tvalid && n < 20) begin
                tick();
                n++;
            end
            check_eq("bp_burst_len", 32'(n), 32'd5);
        end
        m_axis_tready = 1'b0;

        // Overflow: DEPTH accepted, three dropped.
        for (int i = 0; i < DEPTH + 3; i++)
            send(12'($urandom_range(0, 4095)), i < DEPTH);
        check_eq("ovf_level", 32'(fifo_level), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_drops", 32'(drop_count), 32'd3);

        // Full with simultaneous pop: the write is accepted and lands last.
        m_axis_tready = 1'b1;
        send(12'h5A5, 1'b1);
        m_axis_tready = 1'b0;
        check_eq("fullpop_level", 32'(fifo_level), 32'd16);
        check_eq("fullpop_drops", 32'(drop_count), 32'd3);

        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check_eq("clr_flag", 32'(overflow), 32'd0);
        check_eq("clr_drops", 32'(drop_count), 32'd0);

        // Saturation while full.
        adc_valid = 1'b1;
        adc_data  = 12'h123;
        repeat (65540) tick();
        adc_valid = 1'b0;
        check_eq("sat_drops", 32'(drop_count), 32'hFFFF);
        check_eq("sat_flag", 32'(overflow), 32'd1);

        // Drop coinciding with clear: the drop wins.
        adc_valid    = 1'b1;
        overflow_clr = 1'b1;
        tick();
        adc_valid    = 1'b0;
        overflow_clr = 1'b0;
        check_eq("clrdrop_flag", 32'(overflow), 32'd1);
        check_eq("clrdrop_drops", 32'(drop_count), 32'd1);

        // Drain, including the sample appended during the full+pop cycle.
        m_axis_tready = 1'b1;
        wait_empty();
        check_eq("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
        m_axis_tready = 1'b0;

        // Reset mid-stream with seven buffered samples.
        for (int i = 0; i < 7; i++)
            send(12'($urandom_range(0, 4095)), 1'b1);
        check_eq("pre_rst_level", 32'(fifo_level), 32'd7);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
        check_eq("mid_rst_drops", 32'(drop_count), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        m_axis_tready = 1'b1;
        send(12'hABC, 1'b1);
        check_eq("post_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
        check_eq("post_rst_tdata", 32'(m_axis_tdata), 32'h2BC0);
        tick();
        wait_empty();
        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_adc_sample_src.md
Name: axis_adc_sample_src

Overview:
- AXI-Stream master source that feeds the bandpass FIR filter's 16-bit signed sample input.
- Accepts raw 12-bit offset-binary ADC samples on a one-cycle strobe, at about 500 Hz.
- Converts each sample to signed 16-bit, buffers it in a small first-word-fall-through FIFO, and presents it on m_axis with full tvalid/tready handshake.
- Drops samples when the FIFO is full and reports the loss through a sticky flag and a drop counter.

Parameters:
- DEPTH, 16, FIFO depth in samples; power of 2, minimum 2.
- ADC_W, 12, raw ADC sample width; offset-binary coding.
- AXIS_W, 16, output tdata width; signed two's complement.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- adc_valid  in  1  one-cycle strobe; adc_data is valid this cycle
- adc_data  in  ADC_W  raw sample, offset binary (0x800 = mid-scale)
- m_axis_tvalid  out  1  output sample available
- m_axis_tdata  out  AXIS_W  signed output sample
- m_axis_tready  in  1  downstream ready (FIR s_axis_tready)
- overflow_clr  in  1  clears overflow; clears drop_count
- overflow  out  1  sticky; set when a sample is dropped
- drop_count  out  16  saturating count of dropped samples
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - FIFO is empty.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - overflow=0, drop_count=0, fifo_level=0.
- Conversion, combinational before the FIFO write:
  - tdata = (adc_data - 2^(ADC_W-1)) << (AXIS_W-ADC_W).
  - Equivalent to inverting the MSB, then left-aligning with zero LSBs.
  - 0x000 -> 0x8000 (-32768); 0x800 -> 0x0000; 0xFFF -> 0x7FF0 (+32752).
  - No rounding and no saturation are needed.
- Push and pop:
  - push = adc_valid && (!full || pop).
  - pop = m_axis_tvalid && m_axis_tready.
- FIFO is first-word-fall-through:
  - m_axis_tvalid = !empty.
  - m_axis_tdata = head entry, registered.
- Latency:
  - A push in cycle N into an empty FIFO gives tvalid=1 with that sample in cycle N+1.
  - There is no combinational path from adc_valid to m_axis_*.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata and tvalid are held stable.
  - tvalid is never deasserted without a transfer.
  - tvalid does not depend on tready.
- Ordering: samples leave in arrival order; no duplication.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - This is legal at full: the write is accepted.
  - At empty, only the push takes effect, because pop requires tvalid.
- Full, with adc_valid=1 and no pop:
  - The sample is discarded.
  - overflow is set in the next cycle.
  - drop_count increments, saturating at 0xFFFF.
- overflow_clr:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- fifo_level:
  - Registered; reflects occupancy after this cycle's push/pop.
  - Ranges 0..DEPTH.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits; the extra bit is the wrap bit.
  - full = (MSBs differ && LSBs equal).
  - empty = (pointers equal).
  - Pointers wrap naturally at 2*DEPTH.
- Reset mid-operation:
  - Buffered samples are discarded immediately (async).
  - tvalid drops the same instant.
  - Downstream sees no partial transfer.

Decomposition:
- Package axis_sample_pkg holds:
  - ADC_W and AXIS_W defaults.
  - ADC_MID = 2^(ADC_W-1).
  - DROP_CNT_W = 16.
  - A function adc_to_s16() implementing the conversion, shared with later stream sources.
- One sub-module: sync_fifo_fwft.
  - Parameters: DEPTH, W.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, level.
  - It contains the pointer and full/empty logic.
- The top level holds the conversion, push/pop gating, and overflow/drop counter.

Test Plan:
- Conversion: with tready=1, drive adc_data 0x000, 0x800, 0xFFF, 0x801 -> tdata -32768, 0, 32752, 16 in order, each exactly one cycle after its strobe.
- Backpressure: with tready=0, push 5 samples -> fifo_level=5, tvalid stays 1, and tdata holds the first sample unchanged. Then raise tready -> the 5 samples stream out back-to-back in order and tvalid drops after the 5th.
- Overflow: with tready=0, push DEPTH+3 samples -> fifo_level=16, overflow=1, drop_count=3. The output order equals the first 16 samples. Pulse overflow_clr -> overflow=0, drop_count=0.
- Full plus simultaneous pop: with the FIFO full, assert adc_valid and tready in the same cycle -> no drop, fifo_level stays 16, and the new sample appears last.
- Saturation: force 65540 drops -> drop_count=0xFFFF, with no wrap.
- Reset mid-stream: assert rst with 7 samples buffered and tready=0 -> tvalid=0 immediately, fifo_level=0, overflow=0. After release, the first new sample is output correctly.
